// File: rtl/ring_rotator.sv
// Rotating register ring with single-element load, net rotation offset and wrap pulse.
// Optional registered parity output enabled by defining RING_PARITY_EN.
module ring_rotator #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 3,
  parameter int unsigned IDXW  = $clog2(DEPTH)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_en,
  input  logic                   i_dir,
  input  logic                   i_load,
  input  logic [IDXW-1:0]        i_load_idx,
  input  logic [WIDTH-1:0]       i_load_data,
  input  logic [IDXW-1:0]        i_rd_idx,
  output logic [WIDTH-1:0]       o_rd_data,
  output logic [WIDTH*DEPTH-1:0] o_ring_flat,
  output logic [IDXW-1:0]        o_rot_pos,
  output logic                   o_wrap,
  output logic                   o_load_err,
  output logic                   o_parity_out
);

  localparam logic [IDXW:0]   DepthW = (IDXW + 1)'(DEPTH);
  localparam logic [IDXW-1:0] RotMax = IDXW'(DEPTH - 1);

  logic [WIDTH-1:0] r_elem [DEPTH];
  logic [WIDTH-1:0] w_elem [DEPTH];
  logic [IDXW-1:0]  r_rot_pos, w_rot_pos;
  logic             r_wrap, w_wrap;
  logic             r_load_err, w_load_err;
  logic             w_load_ok;

  assign w_load_ok = ({1'b0, i_load_idx} < DepthW);

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_elem[i] = r_elem[i];
    end
    w_rot_pos  = r_rot_pos;
    w_wrap     = 1'b0;
    w_load_err = 1'b0;
    if (i_load) begin
      // An in-range load suppresses rotation; an out-of-range one only flags.
      if (w_load_ok) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (i_load_idx == IDXW'(i)) begin
            w_elem[i] = i_load_data;
          end
        end
      end else begin
        w_load_err = 1'b1;
      end
    end else if (i_en) begin
      if (!i_dir) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          w_elem[i] = r_elem[(i + DEPTH - 1) % DEPTH];
        end
        if (r_rot_pos == RotMax) begin
          w_rot_pos = '0;
          w_wrap    = 1'b1;
        end else begin
          w_rot_pos = r_rot_pos + 1'b1;
        end
      end else begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          w_elem[i] = r_elem[(i + 1) % DEPTH];
        end
        if (r_rot_pos == '0) begin
          w_rot_pos = RotMax;
          w_wrap    = 1'b1;
        end else begin
          w_rot_pos = r_rot_pos - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_elem[i] <= WIDTH'(i + 1);
      end
      r_rot_pos  <= '0;
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_elem[i] <= w_elem[i];
      end
      r_rot_pos  <= w_rot_pos;
      r_wrap     <= w_wrap;
      r_load_err <= w_load_err;
    end
  end

`ifdef RING_PARITY_EN
  function automatic logic f_rst_parity();
    logic             p;
    logic [WIDTH-1:0] v;
    p = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      v = WIDTH'(i + 1);
      p = p ^ (^v);
    end
    return p;
  endfunction

  localparam logic RstParity = f_rst_parity();

  logic r_parity;
  logic w_parity;

  always_comb begin
    w_parity = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_parity = w_parity ^ (^w_elem[i]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_parity <= RstParity;
    end else begin
      r_parity <= w_parity;
    end
  end

  assign o_parity_out = r_parity;
`else
  assign o_parity_out = 1'b0;
`endif

  always_comb begin
    o_rd_data   = '0;
    o_ring_flat = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      o_ring_flat[i*WIDTH +: WIDTH] = r_elem[i];
      if (i_rd_idx == IDXW'(i)) begin
        o_rd_data = r_elem[i];
      end
    end
  end

  assign o_rot_pos  = r_rot_pos;
  assign o_wrap     = r_wrap;
  assign o_load_err = r_load_err;

endmodule
